drive_monitor: RTL and testbench

- Receive-side counterpart of the delayed-pulse driver.
- Watches the stretched drive line and recovers two values for each transaction:
  - the front offset: cycles from the request trigger to the line going high;
  - the hold width: cycles the line stays high.
- Flags timeouts, overlapping triggers and spurious pulses.
- Sits in the test infrastructure beside the driver, feeding scoreboards and checkers.

---
 rtl/drive_monitor_pkg.sv | 22 ++
 rtl/drive_monitor_cnt.sv | 28 ++
 rtl/drive_monitor.sv | 169 ++++++++++++++++
 tb/tb_drive_monitor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drive_monitor_pkg.sv
// Shared types and constants for the drive-line monitor: FSM states,
// default timing constants and the measurement record.
package drive_monitor_pkg;

  localparam int unsigned DEF_MAX_WAIT = 40;
  localparam int unsigned DRV_HOLD     = 4;
  localparam int unsigned DEF_CW       = 6;
  localparam int unsigned DEF_WW       = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_HIGH,
    ST_ORPHAN
  } state_e;

  typedef struct packed {
    logic [DEF_CW-1:0] front;
    logic [DEF_WW-1:0] width;
  } meas_t;

endpackage

// File: rtl/drive_monitor_cnt.sv
// Saturating up-counter with clear and enable; clear+enable together
// restarts the count at 1.
module drive_monitor_cnt #(
  parameter int unsigned W = 3
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    if (en && (cnt_d != '1)) cnt_d = cnt_d + W'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/drive_monitor.sv
// Drive-line monitor: measures trigger-to-rise latency and high width of
// the stretched drive line. Optional expected-value check: DRIVE_MONITOR_CHECK_EN.
module drive_monitor
  import drive_monitor_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned WW       = DEF_WW
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          TRIG,
  input  logic          VALID_IN,
  output logic          MEAS_DONE,
  output logic [CW-1:0] MEAS_FRONT,
  output logic [WW-1:0] MEAS_WIDTH,
  output logic          TIMEOUT,
  output logic          OVERLAP,
`ifdef DRIVE_MONITOR_CHECK_EN
  input  logic [CW-1:0] EXP_FRONT,
  input  logic [WW-1:0] EXP_WIDTH,
  output logic          MISMATCH,
`endif
  output logic          SPURIOUS
);

  state_e        state_q, state_d;
  logic [CW-1:0] front_q, front_d;
  logic          meas_done_q, meas_done_d;
  logic [CW-1:0] meas_front_q, meas_front_d;
  logic [WW-1:0] meas_width_q, meas_width_d;
  logic          timeout_q, timeout_d;
  logic          overlap_q, overlap_d;
  logic          spurious_q, spurious_d;
  logic          lat_clr, lat_en, wid_clr, wid_en;
  logic [CW-1:0] lat;
  logic [WW-1:0] wid;

  drive_monitor_cnt #(.W(CW)) u_lat (
    .CLK(CLK), .RST_N(RST_N), .clr(lat_clr), .en(lat_en), .cnt(lat)
  );

  drive_monitor_cnt #(.W(WW)) u_wid (
    .CLK(CLK), .RST_N(RST_N), .clr(wid_clr), .en(wid_en), .cnt(wid)
  );

  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    meas_front_d = meas_front_q;
    meas_width_d = meas_width_q;
    meas_done_d  = 1'b0;
    timeout_d    = 1'b0;
    spurious_d   = 1'b0;
    overlap_d    = TRIG && (state_q != ST_IDLE);
    lat_clr      = 1'b0;
    lat_en       = 1'b0;
    wid_clr      = 1'b0;
    wid_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (TRIG) begin
          if (VALID_IN) begin
            front_d = '0;
            wid_clr = 1'b1;
            wid_en  = 1'b1;
            state_d = ST_HIGH;
          end else begin
            lat_clr = 1'b1;
            lat_en  = 1'b1;
            state_d = ST_WAIT;
          end
        end else if (VALID_IN) begin
          spurious_d = 1'b1;
          state_d    = ST_ORPHAN;
        end
      end
      ST_WAIT: begin
        if (VALID_IN) begin
          front_d = lat;
          wid_clr = 1'b1;
          wid_en  = 1'b1;
          state_d = ST_HIGH;
        end else if (lat == CW'(MAX_WAIT)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          lat_en = 1'b1;
        end
      end
      ST_HIGH: begin
        if (VALID_IN) begin
          wid_en = 1'b1;
        end else begin
          meas_done_d  = 1'b1;
          meas_front_d = front_q;
          meas_width_d = wid;
          state_d      = ST_IDLE;
        end
      end
      ST_ORPHAN: begin
        if (!VALID_IN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      front_q      <= '0;
      meas_done_q  <= 1'b0;
      meas_front_q <= '0;
      meas_width_q <= '0;
      timeout_q    <= 1'b0;
      overlap_q    <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      meas_done_q  <= meas_done_d;
      meas_front_q <= meas_front_d;
      meas_width_q <= meas_width_d;
      timeout_q    <= timeout_d;
      overlap_q    <= overlap_d;
      spurious_q   <= spurious_d;
    end
  end

`ifdef DRIVE_MONITOR_CHECK_EN
  logic [CW-1:0] exp_front_q, exp_front_d;
  logic [WW-1:0] exp_width_q, exp_width_d;
  logic          mismatch_q, mismatch_d;

  // Expectations are latched only when a trigger is accepted from IDLE.
  always_comb begin
    exp_front_d = exp_front_q;
    exp_width_d = exp_width_q;
    if ((state_q == ST_IDLE) && TRIG) begin
      exp_front_d = EXP_FRONT;
      exp_width_d = EXP_WIDTH;
    end
    mismatch_d = timeout_d ||
                 (meas_done_d && ((front_q != exp_front_q) || (wid != exp_width_q)));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_front_q <= '0;
      exp_width_q <= '0;
      mismatch_q  <= 1'b0;
    end else begin
      exp_front_q <= exp_front_d;
      exp_width_q <= exp_width_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign MISMATCH = mismatch_q;
`endif

  assign MEAS_DONE  = meas_done_q;
  assign MEAS_FRONT = meas_front_q;
  assign MEAS_WIDTH = meas_width_q;
  assign TIMEOUT    = timeout_q;
  assign OVERLAP    = overlap_q;
  assign SPURIOUS   = spurious_q;

endmodule

// File: tb/tb_drive_monitor.sv
// Self-checking bench for drive_monitor: scenario table, hand-written corner
// sequences and random traffic against a timestamp-based reference model.
module tb_drive_monitor;
  import drive_monitor_pkg::*;

  localparam int MAXW = 40;

  logic       CLK = 1'b0;
  logic       RST_N, TRIG, VALID_IN;
  logic       MEAS_DONE, TIMEOUT, OVERLAP, SPURIOUS;
  logic [5:0] MEAS_FRONT;
  logic [2:0] MEAS_WIDTH;
`ifdef DRIVE_MONITOR_CHECK_EN
  logic [5:0] exp_front_in;
  logic [2:0] exp_width_in;
  logic       MISMATCH;
  logic [5:0] m_xf;
  logic [2:0] m_xw;
  bit         e_mis;
  int         c_mis;
`endif

  always #5 CLK = ~CLK;

  drive_monitor #(.MAX_WAIT(40), .CW(6), .WW(3)) dut (
    .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG), .VALID_IN(VALID_IN),
    .MEAS_DONE(MEAS_DONE), .MEAS_FRONT(MEAS_FRONT), .MEAS_WIDTH(MEAS_WIDTH),
    .TIMEOUT(TIMEOUT), .OVERLAP(OVERLAP),
`ifdef DRIVE_MONITOR_CHECK_EN
    .EXP_FRONT(exp_front_in), .EXP_WIDTH(exp_width_in), .MISMATCH(MISMATCH),
`endif
    .SPURIOUS(SPURIOUS)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: timestamps of the accepted trigger and the rise.
  bit   m_trig, m_rise, m_orph;
  int   t_n, r_n, n;
  bit   e_done, e_to, e_ovl, e_spur;
  meas_t e_meas;

  int    c_done, c_to, c_ovl, c_spur;
  meas_t o_meas;

  typedef struct {
    int         trig_at;
    int         trig2_at;
    int         rise_at;
    int         hi_len;
    int         e_done;
    logic [5:0] e_front;
    logic [2:0] e_width;
    int         e_to;
    int         e_ovl;
  } vec_t;

  vec_t vecs[6];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, req);
    end
  endfunction

  function automatic void model_reset();
    m_trig = 0; m_rise = 0; m_orph = 0; n = 0; t_n = 0; r_n = 0;
    e_done = 0; e_to = 0; e_ovl = 0; e_spur = 0; e_meas = '0;
`ifdef DRIVE_MONITOR_CHECK_EN
    e_mis = 0; m_xf = '0; m_xw = '0;
`endif
  endfunction

  function automatic void model(bit t, bit v);
    int w;
    e_done = 0; e_to = 0; e_ovl = 0; e_spur = 0;
`ifdef DRIVE_MONITOR_CHECK_EN
    e_mis = 0;
`endif
    if (!m_trig && !m_orph) begin
      if (t) begin
        m_trig = 1; t_n = n;
`ifdef DRIVE_MONITOR_CHECK_EN
        m_xf = exp_front_in; m_xw = exp_width_in;
`endif
        if (v) begin m_rise = 1; r_n = n; end
      end else if (v) begin
        e_spur = 1; m_orph = 1;
      end
    end else begin
      if (t) e_ovl = 1;
      if (m_orph) begin
        if (!v) m_orph = 0;
      end else if (!m_rise) begin
        if (v) begin m_rise = 1; r_n = n; end
        else if (n - t_n == MAXW) begin
          e_to = 1; m_trig = 0;
`ifdef DRIVE_MONITOR_CHECK_EN
          e_mis = 1;
`endif
        end
      end else if (!v) begin
        w = n - r_n;
        if (w > 7) w = 7;
        e_done = 1;
        e_meas.front = 6'(r_n - t_n);
        e_meas.width = 3'(w);
        m_trig = 0; m_rise = 0;
`ifdef DRIVE_MONITOR_CHECK_EN
        e_mis = (e_meas.front != m_xf) || (e_meas.width != m_xw);
`endif
      end
    end
    n++;
  endfunction

  function automatic void clear_obs();
    c_done = 0; c_to = 0; c_ovl = 0; c_spur = 0; o_meas = '0;
`ifdef DRIVE_MONITOR_CHECK_EN
    c_mis = 0;
`endif
  endfunction

  task automatic step(bit t, bit v);
    TRIG = t; VALID_IN = v;
    @(posedge CLK);
    model(t, v);
    @(negedge CLK);
    check("cycle_outputs",
          64'({MEAS_DONE, MEAS_FRONT, MEAS_WIDTH, TIMEOUT, OVERLAP, SPURIOUS}),
          64'({e_done, e_meas.front, e_meas.width, e_to, e_ovl, e_spur}));
`ifdef DRIVE_MONITOR_CHECK_EN
    check("mismatch", 64'(MISMATCH), 64'(e_mis));
    c_mis += int'(MISMATCH);
`endif
    c_done += int'(MEAS_DONE);
    c_to   += int'(TIMEOUT);
    c_ovl  += int'(OVERLAP);
    c_spur += int'(SPURIOUS);
    if (MEAS_DONE) begin o_meas.front = MEAS_FRONT; o_meas.width = MEAS_WIDTH; end
  endtask

  task automatic run_vec(input vec_t x);
    bit v;
    clear_obs();
    for (int c = 0; c < 60; c++) begin
      v = (x.rise_at >= 0) && (c >= x.rise_at) && (c < x.rise_at + x.hi_len);
      step((c == x.trig_at) || (c == x.trig2_at), v);
    end
    check("vec_done_count", 64'(c_done), 64'(x.e_done));
    check("vec_timeout_count", 64'(c_to), 64'(x.e_to));
    check("vec_overlap_count", 64'(c_ovl), 64'(x.e_ovl));
    check("vec_spurious_count", 64'(c_spur), 64'(0));
    if (x.e_done != 0) begin
      check("vec_front", 64'(o_meas.front), 64'(x.e_front));
      check("vec_width", 64'(o_meas.width), 64'(x.e_width));
    end
  endtask

  initial begin
    bit vcur;
    int run;

    vecs[0] = '{0, -1,  5, DRV_HOLD, 1, 6'd5,  3'd4, 0, 0};
    vecs[1] = '{0, -1,  0, DRV_HOLD, 1, 6'd0,  3'd4, 0, 0};
    vecs[2] = '{0,  2,  6, 10,       1, 6'd6,  3'd7, 0, 1};
    vecs[3] = '{0, -1, -1, 0,        0, 6'd0,  3'd0, 1, 0};
    vecs[4] = '{0, -1, 40, 1,        1, 6'd40, 3'd1, 0, 0};
    vecs[5] = '{0,  5,  2, 3,        1, 6'd2,  3'd3, 0, 1};

    RST_N = 1'b0; TRIG = 1'b0; VALID_IN = 1'b0;
`ifdef DRIVE_MONITOR_CHECK_EN
    exp_front_in = 6'd5; exp_width_in = 3'd4;
`endif
    model_reset();
    repeat (3) @(negedge CLK);
    check("reset_outputs",
          64'({MEAS_DONE, MEAS_FRONT, MEAS_WIDTH, TIMEOUT, OVERLAP, SPURIOUS}), 64'(0));
    RST_N = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Spurious pulse, then a normal measurement with front 7.
    clear_obs();
    for (int c = 0; c < 30; c++)
      step(c == 10, ((c >= 2) && (c < 5)) || ((c >= 17) && (c < 17 + DRV_HOLD)));
    check("spur_count", 64'(c_spur), 64'(1));
    check("spur_done_count", 64'(c_done), 64'(1));
    check("spur_front", 64'(o_meas.front), 64'(7));
    check("spur_width", 64'(o_meas.width), 64'(4));

    // Back-to-back pulses: second one has no trigger.
    clear_obs();
    for (int c = 0; c < 15; c++)
      step(c == 0, (c == 2) || (c == 3) || (c == 5) || (c == 6));
    check("b2b_done_count", 64'(c_done), 64'(1));
    check("b2b_width", 64'(o_meas.width), 64'(2));
    check("b2b_spur_count", 64'(c_spur), 64'(1));

    // Trigger on the done cycle overlaps; one cycle later starts a new wait.
    clear_obs();
    for (int c = 0; c < 50; c++)
      step((c == 0) || (c == 5) || (c == 6), (c >= 2) && (c < 5));
    check("edge_overlap_count", 64'(c_ovl), 64'(1));
    check("edge_done_count", 64'(c_done), 64'(1));
    check("edge_timeout_count", 64'(c_to), 64'(1));

    // Reset in the middle of a high phase.
    clear_obs();
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    RST_N = 1'b0;
    #1;
    check("reset_mid_outputs",
          64'({MEAS_DONE, MEAS_FRONT, MEAS_WIDTH, TIMEOUT, OVERLAP, SPURIOUS}), 64'(0));
    VALID_IN = 1'b0; TRIG = 1'b0;
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0);
    check("reset_mid_done_count", 64'(c_done), 64'(0));

`ifdef DRIVE_MONITOR_CHECK_EN
    clear_obs();
    exp_front_in = 6'd5; exp_width_in = 3'd4;
    for (int c = 0; c < 15; c++) step(c == 0, (c >= 6) && (c < 10));
    check("chk_front_6_vs_5", 64'(c_mis), 64'(1));
`endif

    // Random traffic against the model.
    vcur = 1'b0; run = 3;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        vcur = ~vcur;
        run = vcur ? int'($urandom_range(1, 9)) : int'($urandom_range(1, 50));
      end
      run--;
`ifdef DRIVE_MONITOR_CHECK_EN
      exp_front_in = 6'($urandom_range(0, 10));
      exp_width_in = 3'($urandom_range(1, 7));
`endif
      step($urandom_range(0, 9) == 0, vcur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
